muldiv_unit: RTL and testbench

Parametrised RISC-V M-extension execution unit with a valid/ready handshake on both sides. It replaces single-cycle multiply and the start/done divider coupling inside the ALU. It sits in the execute stage beside the integer ALU and accepts one operation at a time. Multiply latency is a parameter; divide is iterative with one-cycle special-case shortcuts. It carries a tag for writeback routing and supports pipeline flush.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/md_divider.sv | 65 ++++++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage types: M-extension opcodes, muldiv FSM states
// and small opcode-classification helpers.
// Imported by muldiv_unit and md_divider.
package riscv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_S_IDLE = 2'd0,
    MD_S_MUL  = 2'd1,
    MD_S_DIV  = 2'd2,
    MD_S_DONE = 2'd3
  } md_state_e;

  // True for any divide/remainder operation.
  function automatic logic is_md_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  // True for the divide-side ops that need sign handling.
  function automatic logic is_md_signed(input md_op_e op);
    return op inside {MD_DIV, MD_REM};
  endfunction

  // True for remainder ops (result is the remainder, not the quotient).
  function automatic logic is_md_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/md_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Ports: clk/reset, start (loads operands), abort (kills a running division),
// dividend/divisor in, done (high once XLEN iterations have completed), quotient/remainder out.
module md_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsr_q;
  logic [CW-1:0]   cnt_q;
  logic            active_q;

  // Shift the next dividend bit (MSB of the quotient register) into the remainder.
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] rem_sub;
  logic          fits;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign fits      = rem_shift >= {1'b0, dsr_q};
  assign rem_sub   = rem_shift - {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= CW'(XLEN);
      quo_q    <= dividend;
      rem_q    <= '0;
      dsr_q    <= divisor;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
        quo_q <= {quo_q[XLEN-2:0], fits};
        // After a successful subtract the remainder is below the divisor, so it fits in XLEN bits.
        rem_q <= fits ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
      end else begin
        // Result is held for the one cycle the owner spends on sign fixup.
        active_q <= 1'b0;
      end
    end
  end

  assign done      = active_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension execution unit: pipelined multiply, iterative divide,
// single-cycle divide special cases, one operation in flight, tag passthrough.
// Ports: clk, reset, flush; in_valid/in_ready/in_op/in_a/in_b/in_tag request side;
// out_valid/out_ready/out_result/out_tag result side; busy.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  md_op_e           in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        state_q, state_d;
  md_op_e           op_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic             spec_q;
  logic [MCW-1:0]   mul_cnt_q;
  logic [XLEN-1:0]  result_q;

  logic accept;
  logic load_result;

  // Flush wins over a same-cycle request.
  assign accept = in_valid && in_ready && !flush;

  // ---------------- special-case detection on the incoming request
  logic            spec_in;
  logic [XLEN-1:0] a_abs, b_abs;

  assign spec_in = is_md_div(in_op) &&
                   ((in_b == '0) ||
                    (is_md_signed(in_op) && (in_a == MIN_INT) && (in_b == '1)));
  assign a_abs   = (is_md_signed(in_op) && in_a[XLEN-1]) ? -in_a : in_a;
  assign b_abs   = (is_md_signed(in_op) && in_b[XLEN-1]) ? -in_b : in_b;

  // ---------------- divider
  logic            div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  md_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_md_div(in_op) && !spec_in),
    .abort     (flush),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // ---------------- multiplier: operands extended to XLEN+1 bits, then to the full
  // product width so a plain unsigned multiply yields the correct two's-complement bits.
  logic            a_sgn, b_sgn;
  logic [XLEN:0]   a_ext, b_ext;
  logic [2*XLEN+1:0] a_wide, b_wide, prod_wide;
  logic [2*XLEN-1:0] prod_comb, prod_last;
  logic            unused_prod_hi;

  assign a_sgn     = op_q inside {MD_MULH, MD_MULHSU};
  assign b_sgn     = (op_q == MD_MULH);
  assign a_ext     = {a_sgn & a_q[XLEN-1], a_q};
  assign b_ext     = {b_sgn & b_q[XLEN-1], b_q};
  assign a_wide    = {{(XLEN+1){a_ext[XLEN]}}, a_ext};
  assign b_wide    = {{(XLEN+1){b_ext[XLEN]}}, b_ext};
  assign prod_wide = a_wide * b_wide;
  assign prod_comb = prod_wide[2*XLEN-1:0];
  assign unused_prod_hi = ^prod_wide[2*XLEN+1:2*XLEN];

  // MUL_LAT-1 pipeline stages here; result_q is the final stage.
  generate
    if (MUL_LAT == 1) begin : g_nopipe
      assign prod_last = prod_comb;
    end else begin : g_pipe
      logic [2*XLEN-1:0] pipe [MUL_LAT-1];
      always_ff @(posedge clk) begin
        pipe[0] <= prod_comb;
        for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign prod_last = pipe[MUL_LAT-2];
    end
  endgenerate

  // ---------------- result selection
  logic [XLEN-1:0] mul_res, spec_res, div_res, result_d;
  logic            neg_q, neg_r;

  assign neg_q = is_md_signed(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign neg_r = is_md_signed(op_q) && a_q[XLEN-1];

  always_comb begin
    mul_res  = (op_q == MD_MUL) ? prod_last[XLEN-1:0] : prod_last[2*XLEN-1:XLEN];
    spec_res = (b_q == '0) ? (is_md_rem(op_q) ? a_q : '1)
                           : (is_md_rem(op_q) ? '0  : MIN_INT);
    div_res  = is_md_rem(op_q) ? (neg_r ? -div_rem : div_rem)
                               : (neg_q ? -div_quo : div_quo);
    result_d = div_res;
    if (state_q == MD_S_MUL) result_d = mul_res;
    else if (spec_q)         result_d = spec_res;
  end

  // ---------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_S_IDLE: if (accept) state_d = is_md_div(in_op) ? MD_S_DIV : MD_S_MUL;
      MD_S_MUL:  if (mul_cnt_q == '0) state_d = MD_S_DONE;
      MD_S_DIV:  if (spec_q || div_done) state_d = MD_S_DONE;
      MD_S_DONE: if (out_ready) state_d = MD_S_IDLE;
      default:   state_d = MD_S_IDLE;
    endcase
    if (flush) state_d = MD_S_IDLE;
  end

  // A flushed operation never reaches DONE, so its result is never loaded.
  assign load_result = (state_q != MD_S_DONE) && (state_d == MD_S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= MD_MUL;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      spec_q    <= 1'b0;
      mul_cnt_q <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        op_q      <= in_op;
        a_q       <= in_a;
        b_q       <= in_b;
        tag_q     <= in_tag;
        spec_q    <= spec_in;
        mul_cnt_q <= MCW'(MUL_LAT - 1);
      end else if (state_q == MD_S_MUL && mul_cnt_q != '0) begin
        mul_cnt_q <= mul_cnt_q - MCW'(1);
      end
      if (load_result) result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == MD_S_IDLE);
  assign busy       = (state_q != MD_S_IDLE);
  assign out_valid  = (state_q == MD_S_DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready, sel16;
  md_op_e      in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;

  logic        ir32, ov32, busy32, ir16, ov16, busy16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic [4:0]  tag32, tag16;
  logic        iv32, iv16;

  assign iv32 = in_valid & ~sel16;
  assign iv16 = in_valid & sel16;

  muldiv_unit #(.XLEN(32), .MUL_LAT(2), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv32), .in_ready(ir32), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_result(res32), .out_tag(tag32), .busy(busy32));

  muldiv_unit #(.XLEN(16), .MUL_LAT(3), .TAG_W(5)) dut16 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv16), .in_ready(ir16), .in_op(in_op), .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_tag(in_tag),
    .out_valid(ov16), .out_ready(out_ready), .out_result(res16), .out_tag(tag16), .busy(busy16));

  // Currently selected DUT's outputs.
  logic        c_ready, c_valid, c_busy;
  logic [31:0] c_res;
  logic [4:0]  c_tag;
  assign c_ready = sel16 ? ir16 : ir32;
  assign c_valid = sel16 ? ov16 : ov32;
  assign c_busy  = sel16 ? busy16 : busy32;
  assign c_res   = sel16 ? {16'h0, res16} : res32;
  assign c_tag   = sel16 ? tag16 : tag32;

  int n_tests = 0;
  int n_fail  = 0;

  // Independent reference model of the M extension for width xl (16 or 32).
  function automatic logic [31:0] model(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input int xl);
    logic [63:0] mask, ua, ub, up, r;
    longint      sa, sb, sp, minv;
    mask = (64'd1 << xl) - 64'd1;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    sa   = a[xl-1] ? longint'(ua) - longint'(64'd1 << xl) : longint'(ua);
    sb   = b[xl-1] ? longint'(ub) - longint'(64'd1 << xl) : longint'(ub);
    minv = -longint'(64'd1 << (xl - 1));
    case (op)
      MD_MUL:    begin sp = sa * sb;            r = 64'(sp); end
      MD_MULH:   begin sp = sa * sb;            r = 64'(sp >>> xl); end
      MD_MULHSU: begin sp = sa * longint'(ub);  r = 64'(sp >>> xl); end
      MD_MULHU:  begin up = ua * ub;            r = up >> xl; end
      MD_DIV:    if (ub == 0) r = mask; else if (sa == minv && sb == -1) r = 64'(minv); else r = 64'(sa / sb);
      MD_DIVU:   r = (ub == 0) ? mask : ua / ub;
      MD_REM:    if (ub == 0) r = ua; else if (sa == minv && sb == -1) r = 0; else r = 64'(sa % sb);
      default:   r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick(input int xl);
    logic [31:0] mask, v;
    mask = (xl == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = mask;
      3: v = 32'h1 << (xl - 1);
      4: v = 32'($urandom_range(1, 20));
      default: v = $urandom & mask;
    endcase
    return v;
  endfunction

  // Issue one request to the selected DUT and wait (bounded) for out_valid.
  // lat counts edges after the accept edge; the result is not consumed here.
  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int lat, output logic got);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 50 && !c_ready; i++) begin @(posedge clk); #1; end
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (c_valid) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel16 = 1'b0;
    in_op = MD_MUL; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_tests++; if (ov32 !== 1'b0)     begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov32); end
    n_tests++; if (res32 !== 32'h0)   begin n_fail++; $display("FAIL reset_out_result: got %h expected 0", res32); end
    n_tests++; if (tag32 !== 5'h0)    begin n_fail++; $display("FAIL reset_out_tag: got %h expected 0", tag32); end
    n_tests++; if (busy32 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy32); end
    n_tests++; if (ir32 !== 1'b1)     begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", ir32); end
    n_tests++; if (busy16 !== 1'b0 || ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_dut16: busy %b valid %b expected 0 0", busy16, ov16); end
  endtask

  task automatic test_mul;
    md_op_e      ops [3] = '{MD_MULH, MD_MULHU, MD_MUL};
    logic [31:0] exp [3] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001};
    int lat; logic got;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i + 1), lat, got);
      n_tests++; if (!got || c_res !== exp[i]) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", i, c_res, exp[i]); end
      n_tests++; if (lat != 2) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected 2", i, lat); end
      n_tests++; if (c_tag !== 5'(i + 1)) begin n_fail++; $display("FAIL mul_tag[%0d]: got %0d expected %0d", i, c_tag, i + 1); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div;
    md_op_e      ops [4] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat; logic got;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 5'(10 + i), lat, got);
      n_tests++; if (!got || c_res !== exp[i]) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, c_res, exp[i]); end
      n_tests++; if (lat != 33) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_special;
    md_op_e      ops [4] = '{MD_DIV, MD_REMU, MD_DIV, MD_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int lat; logic got;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 5'(20 + i), lat, got);
      n_tests++; if (!got || c_res !== exp[i]) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, c_res, exp[i]); end
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat; logic got;
    out_ready = 1'b0;
    issue(MD_MUL, 32'h1234, 32'h100, 5'd17, lat, got);
    n_tests++; if (!got || c_res !== 32'h0012_3400) begin n_fail++; $display("FAIL bp_result: got %h expected 00123400", c_res); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (c_valid !== 1'b1 || c_res !== 32'h0012_3400 || c_tag !== 5'd17 || c_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid %b result %h tag %0d in_ready %b expected 1 00123400 17 0", i, c_valid, c_res, c_tag, c_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL bp_taken_once: out_valid %b expected 0", c_valid); end
    n_tests++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 1", c_ready); end
  endtask

  task automatic test_flush;
    int lat; logic got, seen;
    in_op = MD_DIV; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_tests++; if (c_busy !== 1'b0 || c_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: busy %b in_ready %b expected 0 1", c_busy, c_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (c_valid) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_output: out_valid seen %b expected 0", seen); end
    issue(MD_MUL, 32'd6, 32'd7, 5'd21, lat, got);
    n_tests++; if (!got || c_res !== 32'd42) begin n_fail++; $display("FAIL flush_next_result: got %h expected 0000002a", c_res); end
    n_tests++; if (c_tag !== 5'd21) begin n_fail++; $display("FAIL flush_next_tag: got %0d expected 21", c_tag); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_accept;
    logic seen;
    in_op = MD_MUL; in_a = 32'd3; in_b = 32'd3; in_tag = 5'd5;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_tests++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL flush_accept_busy: got %b expected 0", c_busy); end
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (c_valid) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_accept_output: out_valid seen %b expected 0", seen); end
  endtask

  task automatic test_reset_midop;
    logic seen;
    in_op = MD_REM; in_a = 32'd77; in_b = 32'd5; in_tag = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++; if (c_busy !== 1'b0 || c_res !== 32'h0) begin n_fail++; $display("FAIL reset_midop: busy %b result %h expected 0 0", c_busy, c_res); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (c_valid) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_midop_output: out_valid seen %b expected 0", seen); end
  endtask

  task automatic test_random(input bit use16, input int n);
    int xl, mlat, lat, exp_lat, hold;
    logic got, spec;
    md_op_e op;
    logic [31:0] a, b, exp, mask, minv;
    logic [4:0] tag;
    xl   = use16 ? 16 : 32;
    mlat = use16 ? 3 : 2;
    mask = use16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    minv = 32'h1 << (xl - 1);
    sel16 = use16;
    out_ready = 1'b0;
    #0;
    for (int k = 0; k < n; k++) begin
      op  = md_op_e'($urandom_range(0, 7));
      a   = pick(xl);
      b   = pick(xl);
      tag = 5'($urandom_range(0, 31));
      exp = model(op, a, b, xl);
      spec = (b == 32'h0) || ((op == MD_DIV || op == MD_REM) && a == minv && b == mask);
      exp_lat = (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU}) ? mlat : (spec ? 1 : xl + 1);
      issue(op, a, b, tag, lat, got);
      n_tests++; if (!got || c_res !== exp) begin n_fail++; $display("FAIL rand%0d_result[%0d]: op %0d a %h b %h got %h expected %h", xl, k, op, a, b, c_res, exp); end
      n_tests++; if (c_tag !== tag) begin n_fail++; $display("FAIL rand%0d_tag[%0d]: got %0d expected %0d", xl, k, c_tag, tag); end
      n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL rand%0d_latency[%0d]: op %0d got %0d expected %0d", xl, k, op, lat, exp_lat); end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        n_tests++; if (c_valid !== 1'b1 || c_res !== exp) begin n_fail++; $display("FAIL rand%0d_hold[%0d]: valid %b result %h expected 1 %h", xl, k, c_valid, c_res, exp); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_tests++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL rand%0d_consume[%0d]: out_valid %b expected 0", xl, k, c_valid); end
    end
    out_ready = 1'b1;
    sel16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_flush_accept();
    test_reset_midop();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
